// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_seq_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StHold     = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFail     = 3'd4
  } pll_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer in the refclk domain. Define PLL_SEQ_LOL_RESTART_EN to
// re-pulse the PLL reset on loss of lock in RUN instead of waiting for it to relock.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYC     = 50,
  parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned MAX_RETRIES      = 3
) (
  input  logic                             refclk,
  input  logic                             rst,
  input  logic                             restart,
  input  logic                             pll_locked,
  output logic                             pll_rst,
  output logic                             sys_rst,
  output logic                             fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt,
  output logic [StateW-1:0]                state_o
);

  localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);
  localparam int unsigned TmrMax = max3(RST_HOLD_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);

  localparam logic [TmrW-1:0]   HoldLoad    = TmrW'(RST_HOLD_CYC - 1);
  localparam logic [TmrW-1:0]   TimeoutLoad = TmrW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [TmrW-1:0]   StableLoad  = TmrW'(LOCK_STABLE_CYC - 1);
  localparam logic [RetryW-1:0] MaxRetry    = RetryW'(MAX_RETRIES);

  pll_state_e        state_q, state_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic [RetryW-1:0] retry_q, retry_d, retry_inc;
  logic              pll_rst_q, pll_rst_d;
  logic              sys_rst_q, sys_rst_d;
  logic              fail_q, fail_d;
  logic              lk;

  sync_2ff u_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  assign retry_inc = (retry_q == MaxRetry) ? retry_q : retry_q + RetryW'(1);

  always_comb begin
    state_d = state_q;
    tmr_d   = (tmr_q != '0) ? tmr_q - TmrW'(1) : tmr_q;
    retry_d = retry_q;
    if (restart) begin
      state_d = StHold;
      tmr_d   = HoldLoad;
      retry_d = '0;
    end else begin
      unique case (state_q)
        StHold: begin
          if (tmr_q == '0) begin
            state_d = StWaitLock;
            tmr_d   = TimeoutLoad;
          end
        end
        StWaitLock: begin
          // Lock beats a coincident timeout, so no retry is charged.
          if (lk) begin
            state_d = StStable;
            tmr_d   = StableLoad;
          end else if (tmr_q == '0) begin
            retry_d = retry_inc;
            if (retry_inc == MaxRetry) begin
              state_d = StFail;
            end else begin
              state_d = StHold;
              tmr_d   = HoldLoad;
            end
          end
        end
        StStable: begin
          if (!lk) begin
            state_d = StWaitLock;
            tmr_d   = TimeoutLoad;
          end else if (tmr_q == '0) begin
            state_d = StRun;
            retry_d = '0;
          end
        end
        StRun: begin
          if (!lk) begin
`ifdef PLL_SEQ_LOL_RESTART_EN
            state_d = StHold;
            tmr_d   = HoldLoad;
`else
            state_d = StWaitLock;
            tmr_d   = TimeoutLoad;
`endif
          end
        end
        StFail: state_d = StFail;
        default: begin
          state_d = StHold;
          tmr_d   = HoldLoad;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they flip on the same edge as the state.
  always_comb begin
    pll_rst_d = (state_d == StHold) || (state_d == StFail);
    sys_rst_d = (state_d != StRun);
    fail_d    = (state_d == StFail);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= StHold;
      tmr_q     <= HoldLoad;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      fail_q    <= fail_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: each stimulus step queues the output changes it should cause,
// and a negedge monitor pops and compares them as the outputs actually change.
module tb_pll_reset_sequencer;

  localparam int unsigned HoldCyc = 4;
  localparam int unsigned ToCyc   = 20;
  localparam int unsigned StabCyc = 8;
  localparam int unsigned MaxRet  = 2;

  localparam logic [2:0] Hold   = 3'd0;
  localparam logic [2:0] WaitLk = 3'd1;
  localparam logic [2:0] Stable = 3'd2;
  localparam logic [2:0] Run    = 3'd3;
  localparam logic [2:0] Fail   = 3'd4;

  logic       refclk = 1'b0;
  logic       rst, restart, pll_locked;
  logic       pll_rst, sys_rst, fail;
  logic [1:0] retry_cnt;
  logic [2:0] state_o;

  pll_reset_sequencer #(
    .RST_HOLD_CYC     (HoldCyc),
    .LOCK_TIMEOUT_CYC (ToCyc),
    .LOCK_STABLE_CYC  (StabCyc),
    .MAX_RETRIES      (MaxRet)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .restart    (restart),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .state_o    (state_o)
  );

  always #5 refclk = ~refclk;

  int unsigned cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    int unsigned at;
    logic [7:0]  val;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_ev(input string tag, input int unsigned at, input logic [2:0] st,
                           input logic pr, input logic sr, input logic fl,
                           input logic [1:0] rc);
    ev_t e;
    e.tag = tag;
    e.at  = at;
    e.val = {st, pr, sr, fl, rc};
    exp_q.push_back(e);
  endtask

  // Monitor: every observed output change must match the next queued expectation.
  logic [7:0] prev = {Hold, 1'b1, 1'b1, 1'b0, 2'd0};
  logic [7:0] obs;
  ev_t        mon_e;
  initial begin
    forever begin
      @(negedge refclk);
      obs = {state_o, pll_rst, sys_rst, fail, retry_cnt};
      if (obs !== prev) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_change", {24'd0, obs}, {24'd0, prev});
        end else begin
          mon_e = exp_q.pop_front();
          check_val({mon_e.tag, "_at"}, cyc, mon_e.at);
          check_val(mon_e.tag, {24'd0, obs}, {24'd0, mon_e.val});
        end
        prev = obs;
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge refclk);
    restart = 1'b0;
  endtask

  initial begin
    int unsigned k;
    rst        = 1'b1;
    restart    = 1'b0;
    pll_locked = 1'b0;
    tick(2);
    check_val("rst_state", {29'd0, state_o}, {29'd0, Hold});
    check_val("rst_pll_rst", {31'd0, pll_rst}, 32'd1);
    check_val("rst_sys_rst", {31'd0, sys_rst}, 32'd1);
    check_val("rst_fail", {31'd0, fail}, 32'd0);
    check_val("rst_retry", {30'd0, retry_cnt}, 32'd0);

    // Nominal lock: pll_rst high for 4 cycles, lock 5 cycles later, sys_rst 11 edges on.
    k = cyc;
    expect_ev("nom_wait", k + 4, WaitLk, 1'b0, 1'b1, 1'b0, 2'd0);
    rst = 1'b0;
    tick(9);
    k = cyc;
    expect_ev("nom_stable", k + 3, Stable, 1'b0, 1'b1, 1'b0, 2'd0);
    expect_ev("nom_run", k + 11, Run, 1'b0, 1'b0, 1'b0, 2'd0);
    pll_locked = 1'b1;
    tick(14);
    check_val("nom_retry", {30'd0, retry_cnt}, 32'd0);

    // Lock glitch during STABLE restarts the full qualification.
    k = cyc;
    expect_ev("gl_hold", k + 1, Hold, 1'b1, 1'b1, 1'b0, 2'd0);
    expect_ev("gl_wait", k + 5, WaitLk, 1'b0, 1'b1, 1'b0, 2'd0);
    expect_ev("gl_stable", k + 6, Stable, 1'b0, 1'b1, 1'b0, 2'd0);
    pulse_restart();
    tick(7);
    k = cyc;
    expect_ev("gl_drop", k + 3, WaitLk, 1'b0, 1'b1, 1'b0, 2'd0);
    expect_ev("gl_restable", k + 6, Stable, 1'b0, 1'b1, 1'b0, 2'd0);
    expect_ev("gl_run", k + 14, Run, 1'b0, 1'b0, 1'b0, 2'd0);
    pll_locked = 1'b0;
    tick(3);
    pll_locked = 1'b1;
    tick(14);

    // Timeout and retry into FAIL.
    k = cyc;
    expect_ev("to_hold", k + 1, Hold, 1'b1, 1'b1, 1'b0, 2'd0);
    expect_ev("to_wait1", k + 5, WaitLk, 1'b0, 1'b1, 1'b0, 2'd0);
    expect_ev("to_retry1", k + 25, Hold, 1'b1, 1'b1, 1'b0, 2'd1);
    expect_ev("to_wait2", k + 29, WaitLk, 1'b0, 1'b1, 1'b0, 2'd1);
    expect_ev("to_fail", k + 49, Fail, 1'b1, 1'b1, 1'b1, 2'd2);
    pll_locked = 1'b0;
    pulse_restart();
    tick(55);
    check_val("fail_flag", {31'd0, fail}, 32'd1);
    check_val("fail_pll_rst", {31'd0, pll_rst}, 32'd1);

    // Restart out of FAIL, then restart coincident with a WAIT_LOCK timeout.
    k = cyc;
    expect_ev("rs_hold", k + 1, Hold, 1'b1, 1'b1, 1'b0, 2'd0);
    expect_ev("rs_wait", k + 5, WaitLk, 1'b0, 1'b1, 1'b0, 2'd0);
    expect_ev("prio_hold", k + 25, Hold, 1'b1, 1'b1, 1'b0, 2'd0);
    expect_ev("prio_wait", k + 29, WaitLk, 1'b0, 1'b1, 1'b0, 2'd0);
    pulse_restart();
    tick(23);
    pulse_restart();
    check_val("prio_retry", {30'd0, retry_cnt}, 32'd0);
    tick(5);

    // Lock, then lose it in RUN.
    k = cyc;
    expect_ev("lol_stable", k + 3, Stable, 1'b0, 1'b1, 1'b0, 2'd0);
    expect_ev("lol_run", k + 11, Run, 1'b0, 1'b0, 1'b0, 2'd0);
    pll_locked = 1'b1;
    tick(14);
    k = cyc;
`ifdef PLL_SEQ_LOL_RESTART_EN
    expect_ev("lol_hold", k + 3, Hold, 1'b1, 1'b1, 1'b0, 2'd0);
    expect_ev("lol_wait", k + 7, WaitLk, 1'b0, 1'b1, 1'b0, 2'd0);
`else
    expect_ev("lol_wait", k + 3, WaitLk, 1'b0, 1'b1, 1'b0, 2'd0);
`endif
    expect_ev("lol_restable", k + 11, Stable, 1'b0, 1'b1, 1'b0, 2'd0);
    expect_ev("lol_rerun", k + 19, Run, 1'b0, 1'b0, 1'b0, 2'd0);
    pll_locked = 1'b0;
    tick(8);
    pll_locked = 1'b1;
    tick(14);

    // Asynchronous reset mid-cycle while in RUN.
    @(posedge refclk);
    #2;
    k = cyc;
    expect_ev("ar_hold", k, Hold, 1'b1, 1'b1, 1'b0, 2'd0);
    rst = 1'b1;
    #1;
    check_val("ar_pll_rst", {31'd0, pll_rst}, 32'd1);
    check_val("ar_sys_rst", {31'd0, sys_rst}, 32'd1);
    tick(3);
    k = cyc;
    expect_ev("ar_wait", k + 4, WaitLk, 1'b0, 1'b1, 1'b0, 2'd0);
    expect_ev("ar_stable", k + 5, Stable, 1'b0, 1'b1, 1'b0, 2'd0);
    expect_ev("ar_run", k + 13, Run, 1'b0, 1'b0, 1'b0, 2'd0);
    rst = 1'b0;
    tick(16);

    check_val("drain", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
